// File: rtl/nv_nvdla_cacc_slcg_pkg.sv
// Shared types and constants for the CACC second-level clock-gate controller.
// Consumers: nv_nvdla_cacc_slcg_ctrl and nv_nvdla_cacc_slcg_dncnt.
package nv_nvdla_cacc_slcg_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } slcg_state_e;

  localparam int DEF_IDLE_CYCLES = 16;
  localparam int DEF_WAKE_CYCLES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int STAT_W          = 32;

endpackage

// File: rtl/nv_nvdla_cacc_slcg_dncnt.sv
// Loadable down-counter shared by the drain and wake phases of the SLCG FSM.
// Decrement stops at zero; load takes priority over decrement.
module nv_nvdla_cacc_slcg_dncnt
  import nv_nvdla_cacc_slcg_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/nv_nvdla_cacc_slcg_ctrl.sv
// CACC SLCG enable producer: drains IDLE_CYCLES idle cycles before gating, and
// re-enables with a WAKE_CYCLES settle before wake_ack. Optional gated-cycle
// statistic is built only when NV_NVDLA_CACC_SLCG_GATED_CNT_EN is defined.
module nv_nvdla_cacc_slcg_ctrl
  import nv_nvdla_cacc_slcg_pkg::*;
#(
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              nvdla_core_clk,
  input  logic              nvdla_core_rstn,
  input  logic              busy,
  input  logic              wake_req,
  input  logic              dla_clk_ovr_on_sync,
  input  logic              global_clk_ovr_on_sync,
  input  logic              tmc2slcg_disable_clock_gating,
  output logic              slcg_en,
  output logic              wake_ack,
  output logic [STAT_W-1:0] gated_cycles
);

  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

  slcg_state_e      state;
  logic             slcg_en_r;
  logic             ovr;
  logic             act;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_dec;
  logic             cnt_zero;

  assign ovr     = dla_clk_ovr_on_sync | global_clk_ovr_on_sync | tmc2slcg_disable_clock_gating;
  assign act     = busy | wake_req;
  assign slcg_en = slcg_en_r | ovr;

  // One counter serves both the idle window (DRAIN) and the settle window (WAKE).
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = 1'b0;
    if (ovr) begin
      cnt_load = 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          if (!act) begin
            cnt_load = 1'b1;
            cnt_val  = IDLE_LOAD;
          end
        end
        ST_DRAIN: cnt_dec = !act && !cnt_zero;
        ST_GATED: begin
          if (act) begin
            cnt_load = 1'b1;
            cnt_val  = WAKE_LOAD;
          end
        end
        ST_WAKE:  cnt_dec = !cnt_zero;
        default:  cnt_dec = 1'b0;
      endcase
    end
  end

  nv_nvdla_cacc_slcg_dncnt #(.CNT_W(CNT_W)) u_dncnt (
    .clk      (nvdla_core_clk),
    .rst_n    (nvdla_core_rstn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state     <= ST_RUN;
      slcg_en_r <= 1'b1;
      wake_ack  <= 1'b1;
    end else if (ovr) begin
      state     <= ST_RUN;
      slcg_en_r <= 1'b1;
      wake_ack  <= 1'b1;
    end else begin
      case (state)
        ST_RUN: begin
          wake_ack <= 1'b1;
          if (!act) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (act) begin
            state    <= ST_RUN;
            wake_ack <= 1'b1;
          end else if (cnt_zero) begin
            state     <= ST_GATED;
            slcg_en_r <= 1'b0;
            wake_ack  <= 1'b0;
          end else begin
            wake_ack <= 1'b1;
          end
        end
        ST_GATED: begin
          wake_ack <= 1'b0;
          if (act) begin
            state     <= ST_WAKE;
            slcg_en_r <= 1'b1;
          end
        end
        ST_WAKE: begin
          // A dropped request does not abort the wake; it completes and re-drains.
          if (cnt_zero) begin
            state    <= ST_RUN;
            wake_ack <= 1'b1;
          end else begin
            wake_ack <= 1'b0;
          end
        end
        default: begin
          state     <= ST_RUN;
          slcg_en_r <= 1'b1;
          wake_ack  <= 1'b1;
        end
      endcase
    end
  end

`ifdef NV_NVDLA_CACC_SLCG_GATED_CNT_EN
  logic [STAT_W-1:0] gated_cnt;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      gated_cnt <= '0;
    end else if (!slcg_en && (gated_cnt != {STAT_W{1'b1}})) begin
      gated_cnt <= gated_cnt + 1'b1;
    end
  end

  assign gated_cycles = gated_cnt;
`else
  assign gated_cycles = '0;
`endif

endmodule

// File: tb/tb_nv_nvdla_cacc_slcg_ctrl.sv
// Self-checking bench for nv_nvdla_cacc_slcg_ctrl: directed scenarios plus
// randomized traffic checked against an idle-streak / wake-timer model.
module tb_nv_nvdla_cacc_slcg_ctrl;

  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic        nvdla_core_clk = 1'b0;
  logic        nvdla_core_rstn;
  logic        busy, wake_req;
  logic        dla_clk_ovr_on_sync, global_clk_ovr_on_sync, tmc2slcg_disable_clock_gating;
  logic        slcg_en, wake_ack;
  logic [31:0] gated_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  nv_nvdla_cacc_slcg_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(8)) dut (
    .nvdla_core_clk                (nvdla_core_clk),
    .nvdla_core_rstn               (nvdla_core_rstn),
    .busy                          (busy),
    .wake_req                      (wake_req),
    .dla_clk_ovr_on_sync           (dla_clk_ovr_on_sync),
    .global_clk_ovr_on_sync        (global_clk_ovr_on_sync),
    .tmc2slcg_disable_clock_gating (tmc2slcg_disable_clock_gating),
    .slcg_en                       (slcg_en),
    .wake_ack                      (wake_ack),
    .gated_cycles                  (gated_cycles)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  // Model: the clock is "on" until IDLE+1 consecutive idle edges have been seen;
  // a wake takes WAKE edges after the request edge before ack returns.
  typedef enum {M_ON, M_OFF, M_WAKING} mmode_e;
  mmode_e m_mode;
  int     m_streak, m_wake_left;
  bit     m_en_r, m_ack;
  longint m_gc;

  function automatic bit cur_ovr();
    return dla_clk_ovr_on_sync | global_clk_ovr_on_sync | tmc2slcg_disable_clock_gating;
  endfunction

  function automatic logic exp_en();
    return logic'(m_en_r | cur_ovr());
  endfunction

  function automatic logic [31:0] exp_gc();
`ifdef NV_NVDLA_CACC_SLCG_GATED_CNT_EN
    return (m_gc > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_gc[31:0];
`else
    return 32'd0;
`endif
  endfunction

  function automatic void model_reset();
    m_mode = M_ON; m_streak = 0; m_wake_left = 0; m_en_r = 1; m_ack = 1; m_gc = 0;
  endfunction

  function automatic void model_edge();
    bit act;
    act = busy | wake_req;
    if (!(m_en_r | cur_ovr())) m_gc++;
    if (cur_ovr()) begin
      m_mode = M_ON; m_streak = 0; m_en_r = 1; m_ack = 1;
    end else begin
      case (m_mode)
        M_ON: begin
          m_streak = act ? 0 : m_streak + 1;
          if (m_streak == IDLE + 1) begin
            m_mode = M_OFF; m_en_r = 0; m_ack = 0;
          end
        end
        M_OFF: if (act) begin
          m_mode = M_WAKING; m_en_r = 1; m_wake_left = WAKE;
        end
        M_WAKING: begin
          m_wake_left--;
          if (m_wake_left == 0) begin
            m_mode = M_ON; m_ack = 1; m_streak = 0;
          end
        end
        default: m_mode = M_ON;
      endcase
    end
  endfunction

  task automatic step();
    @(posedge nvdla_core_clk);
    model_edge();
    @(negedge nvdla_core_clk);
  endtask

  task automatic set_idle();
    busy = 0; wake_req = 0;
    dla_clk_ovr_on_sync = 0; global_clk_ovr_on_sync = 0; tmc2slcg_disable_clock_gating = 0;
  endtask

  task automatic test_reset();
    set_idle();
    nvdla_core_rstn = 0;
    model_reset();
    repeat (3) @(negedge nvdla_core_clk);
    n_cmp++;
    if (slcg_en !== 1'b1 || wake_ack !== 1'b1 || gated_cycles !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: en=%b ack=%b gc=%0d required en=1 ack=1 gc=0", slcg_en, wake_ack, gated_cycles);
    end
    nvdla_core_rstn = 1;
  endtask

  task automatic test_idle_gating();
    for (int i = 1; i <= IDLE + 1; i++) begin
      step();
      n_cmp++;
      if (slcg_en !== (i <= IDLE) || wake_ack !== (i <= IDLE)) begin
        n_fail++;
        $display("FAIL idle_gating edge %0d: en=%b ack=%b required both %0d", i, slcg_en, wake_ack, (i <= IDLE));
      end
    end
  endtask

  task automatic test_drain_abort();
    // wake out of gating first, then drain 9 idle cycles and pulse busy on the 10th
    wake_req = 1;
    repeat (WAKE + 1) step();
    wake_req = 0;
    repeat (9) step();
    busy = 1; step(); busy = 0;
    for (int i = 1; i <= IDLE + 1; i++) begin
      step();
      n_cmp++;
      if (slcg_en !== (i <= IDLE) || slcg_en !== exp_en() || wake_ack !== m_ack) begin
        n_fail++;
        $display("FAIL drain_abort idle %0d: en=%b ack=%b required en=%b ack=%b", i, slcg_en, wake_ack, exp_en(), m_ack);
      end
    end
  endtask

  task automatic test_wake();
    logic exp_ack [3] = '{1'b0, 1'b0, 1'b1};
    wake_req = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (slcg_en !== 1'b1 || wake_ack !== exp_ack[i]) begin
        n_fail++;
        $display("FAIL wake edge %0d: en=%b ack=%b required en=1 ack=%b", i + 1, slcg_en, wake_ack, exp_ack[i]);
      end
    end
    wake_req = 0;
    for (int i = 1; i <= IDLE + 1; i++) begin
      step();
      n_cmp++;
      if (slcg_en !== (i <= IDLE)) begin
        n_fail++;
        $display("FAIL wake_regate edge %0d: en=%b required %0d", i, slcg_en, (i <= IDLE));
      end
    end
  endtask

  task automatic test_override();
    tmc2slcg_disable_clock_gating = 1;
    #1;
    n_cmp++;
    if (slcg_en !== 1'b1 || wake_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL override_same_cycle: en=%b ack=%b required en=1 ack=0", slcg_en, wake_ack);
    end
    step();
    n_cmp++;
    if (wake_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL override_ack: ack=%b required 1", wake_ack);
    end
    for (int i = 0; i < 100; i++) begin
      step();
      n_cmp++;
      if (slcg_en !== 1'b1 || wake_ack !== 1'b1) begin
        n_fail++;
        $display("FAIL override_hold cycle %0d: en=%b ack=%b required 1/1", i, slcg_en, wake_ack);
      end
    end
    tmc2slcg_disable_clock_gating = 0;
  endtask

  task automatic test_reset_mid_wake();
    repeat (IDLE + 1) step();
    wake_req = 1;
    step();
    n_cmp++;
    if (slcg_en !== 1'b1 || wake_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL pre_reset_wake: en=%b ack=%b required en=1 ack=0", slcg_en, wake_ack);
    end
    #2 nvdla_core_rstn = 0;
    model_reset();
    #1;
    n_cmp++;
    if (slcg_en !== 1'b1 || wake_ack !== 1'b1 || dut.state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_mid_wake: en=%b ack=%b state=%0d required en=1 ack=1 state=0", slcg_en, wake_ack, dut.state);
    end
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1;
    wake_req = 0;
    for (int i = 1; i <= IDLE + 1; i++) begin
      step();
      n_cmp++;
      if (slcg_en !== (i <= IDLE)) begin
        n_fail++;
        $display("FAIL post_reset_drain edge %0d: en=%b required %0d", i, slcg_en, (i <= IDLE));
      end
    end
  endtask

  task automatic test_stat();
    logic [31:0] req;
    nvdla_core_rstn = 0;
    set_idle();
    model_reset();
    @(negedge nvdla_core_clk);
    nvdla_core_rstn = 1;
    // gated from the 17th edge: cycles 17..40 are gated, counted by edge 41
    repeat (41) step();
`ifdef NV_NVDLA_CACC_SLCG_GATED_CNT_EN
    req = 32'd24;
`else
    req = 32'd0;
`endif
    n_cmp++;
    if (gated_cycles !== req) begin
      n_fail++;
      $display("FAIL stat_40_idle: gated_cycles=%0d required %0d", gated_cycles, req);
    end
  endtask

  task automatic test_random();
    int density;
    for (int seg = 0; seg < 12; seg++) begin
      density = $urandom_range(0, 30);
      for (int i = 0; i < 150; i++) begin
        busy     = ($urandom_range(0, 99) < density);
        wake_req = ($urandom_range(0, 99) < density / 3);
        dla_clk_ovr_on_sync           = ($urandom_range(0, 199) == 0);
        global_clk_ovr_on_sync        = ($urandom_range(0, 199) == 0);
        tmc2slcg_disable_clock_gating = ($urandom_range(0, 199) == 0);
        #1;
        n_cmp++;
        if (slcg_en !== exp_en()) begin
          n_fail++;
          $display("FAIL random_comb seg %0d cyc %0d: en=%b required %b", seg, i, slcg_en, exp_en());
        end
        step();
        n_cmp++;
        if (slcg_en !== exp_en() || wake_ack !== m_ack || gated_cycles !== exp_gc()) begin
          n_fail++;
          $display("FAIL random seg %0d cyc %0d: en=%b ack=%b gc=%0d required en=%b ack=%b gc=%0d",
                   seg, i, slcg_en, wake_ack, gated_cycles, exp_en(), m_ack, exp_gc());
        end
      end
    end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_idle_gating();
    test_drain_abort();
    test_wake();
    test_override();
    test_reset_mid_wake();
    test_stat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
